// File: rtl/multi_hex_display.sv
// multi_hex_display: latches a binary value on a load pulse and renders it on
// NUM_DIGITS active-low seven-segment digits, in hexadecimal or decimal.
// Decimal conversion runs an iterative shift-add-3 (double-dabble) engine,
// one input bit per clock. Segment outputs only change on the update edge.
// Optional build macro: LEADING_ZERO_BLANK_EN (blank digits above the most
// significant nonzero digit; digit 0 always shown).
module multi_hex_display #(
    parameter int DATA_WIDTH = 14,
    parameter int NUM_DIGITS = 4
) (
    input  logic                    clock,
    input  logic                    resetn,
    input  logic [DATA_WIDTH-1:0]   value,
    input  logic                    load,
    input  logic                    mode,
    output logic                    busy,
    output logic                    done,
    output logic                    overflow,
    output logic [NUM_DIGITS*7-1:0] hex
);

    // One spare nibble above the displayed digits catches decimal overflow.
    localparam int BCD_W = 4*NUM_DIGITS + 4;
    localparam int EXT_W = DATA_WIDTH + 4*NUM_DIGITS;
    localparam int CNT_W = $clog2(DATA_WIDTH + 1);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] CONVERT = 2'd1;
    localparam logic [1:0] UPDATE  = 2'd2;

    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Active-low gfedcba pattern for one hex digit.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'h0: seg7 = 7'b1000000;
            4'h1: seg7 = 7'b1111001;
            4'h2: seg7 = 7'b0100100;
            4'h3: seg7 = 7'b0110000;
            4'h4: seg7 = 7'b0011001;
            4'h5: seg7 = 7'b0010010;
            4'h6: seg7 = 7'b0000010;
            4'h7: seg7 = 7'b1111000;
            4'h8: seg7 = 7'b0000000;
            4'h9: seg7 = 7'b0010000;
            4'hA: seg7 = 7'b0001000;
            4'hB: seg7 = 7'b0000011;
            4'hC: seg7 = 7'b1000110;
            4'hD: seg7 = 7'b0100001;
            4'hE: seg7 = 7'b0000110;
            default: seg7 = 7'b0001110;
        endcase
    endfunction

    logic [1:0]              state;
    logic [DATA_WIDTH-1:0]   bin_q;
    logic                    mode_q;
    logic [BCD_W-1:0]        bcd_q;
    logic                    lost_q;   // a BCD bit was shifted out of the top nibble
    logic [CNT_W-1:0]        cnt_q;

    logic [BCD_W-1:0]        bcd_adj;
    logic [BCD_W-1:0]        bcd_shift;
    logic [DATA_WIDTH-1:0]   bin_shift;
    logic [EXT_W-1:0]        ext;
    logic                    ovf_next;
    logic [NUM_DIGITS*7-1:0] hex_next;
    logic [3:0]              dig;
`ifdef LEADING_ZERO_BLANK_EN
    logic                    seen_nz;
`endif

    assign busy = (state != IDLE);

    // One double-dabble step: add 3 to every nibble >= 5, then shift {bcd, bin} left.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        bcd_adj = bcd_q;
        for (int k = 0; k <= NUM_DIGITS; k++) begin
            if (bcd_adj[4*k +: 4] >= 4'd5)
                bcd_adj[4*k +: 4] = bcd_adj[4*k +: 4] + 4'd3;
        end
        bcd_shift = {bcd_adj[BCD_W-2:0], bin_q[DATA_WIDTH-1]};
        bin_shift = bin_q << 1;
    end

    // Segment pattern and overflow flag that the update edge will register.
    always_comb begin
        ext      = EXT_W'(bin_q);
        hex_next = '1;
        dig      = 4'd0;
        if (mode_q)
            ovf_next = (bcd_q[BCD_W-1 -: 4] != 4'd0) || lost_q;
        else
            ovf_next = (ext >> (4*NUM_DIGITS)) != '0;
`ifdef LEADING_ZERO_BLANK_EN
        seen_nz = 1'b0;
`endif
        for (int k = NUM_DIGITS-1; k >= 0; k--) begin
            dig = mode_q ? bcd_q[4*k +: 4] : ext[4*k +: 4];
            hex_next[7*k +: 7] = seg7(dig);
`ifdef LEADING_ZERO_BLANK_EN
            seen_nz = seen_nz | (dig != 4'd0);
            if (!seen_nz && k != 0)
                hex_next[7*k +: 7] = SEG_BLANK;
`endif
            if (ovf_next)
                hex_next[7*k +: 7] = SEG_DASH;
        end
    end

    // Capture / convert / update sequencer; display registers change only in UPDATE.
    always_ff @(posedge clock or negedge resetn) begin
        // NOTE: the conversion registers are small, so all of them are reset; an abort leaves no stale state.
        if (!resetn) begin
            state    <= IDLE;
            bin_q    <= '0;
            mode_q   <= 1'b0;
            bcd_q    <= '0;
            lost_q   <= 1'b0;
            cnt_q    <= '0;
            hex      <= '1;
            done     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (load) begin
                        bin_q  <= value;
                        mode_q <= mode;
                        if (mode) begin
                            bcd_q  <= '0;
                            lost_q <= 1'b0;
                            cnt_q  <= CNT_W'(DATA_WIDTH);
                            state  <= CONVERT;
                        end else begin
                            state  <= UPDATE;
                        end
                    end
                end
                CONVERT: begin
                    bcd_q  <= bcd_shift;
                    bin_q  <= bin_shift;
                    lost_q <= lost_q | bcd_adj[BCD_W-1];
                    cnt_q  <= cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1))
                        state <= UPDATE;
                end
                UPDATE: begin
                    hex      <= hex_next;
                    overflow <= ovf_next;
                    done     <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_multi_hex_display.sv
// Directed bench for multi_hex_display at default parameters (14-bit value,
// 4 digits). Expected segment patterns are hand-written constants.
module tb_multi_hex_display;

    localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100, S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001, S5 = 7'b0010010, S6 = 7'b0000010, S7 = 7'b1111000;
    localparam logic [6:0] S8 = 7'b0000000, S9 = 7'b0010000, SA = 7'b0001000, SB = 7'b0000011;
    localparam logic [6:0] SC = 7'b1000110, SF = 7'b0001110;
    localparam logic [6:0] DS = 7'b0111111, BL = 7'b1111111;
`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [6:0] LZ = BL;
`else
    localparam logic [6:0] LZ = S0;
`endif
    localparam logic [27:0] DASHES = {DS, DS, DS, DS};
    localparam logic [27:0] BLANK  = {BL, BL, BL, BL};

    logic        clock;
    logic        resetn;
    logic [13:0] value;
    logic        load;
    logic        mode;
    logic        busy;
    logic        done;
    logic        overflow;
    logic [27:0] hex;

    int total = 0;
    int bad   = 0;

    multi_hex_display #(.DATA_WIDTH(14), .NUM_DIGITS(4)) dut (
        .clock(clock), .resetn(resetn), .value(value), .load(load), .mode(mode),
        .busy(busy), .done(done), .overflow(overflow), .hex(hex)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [13:0] value;
        logic        mode;
        logic [27:0] hex;
        logic        ovf;
        int          busy_n;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    // Issue one load, then wait (bounded) for done; counts busy cycles and any
    // change of hex while the capture is in flight. Returns at the done negedge.
    task automatic run_load(input logic [13:0] v, input logic m,
                            output int busy_n, output logic got_done, output int hold_bad);
        logic [27:0] prev;
        @(negedge clock);
        value = v; mode = m; load = 1'b1;
        prev = hex;
        @(negedge clock);
        load = 1'b0;
        busy_n = 0; got_done = 1'b0; hold_bad = 0;
        for (int i = 0; i < 100; i++) begin
            if (done) begin
                got_done = 1'b1;
                break;
            end
            if (busy) busy_n++;
            if (hex !== prev) hold_bad++;
            @(negedge clock);
        end
    endtask

    initial begin
        int          busy_n;
        logic        got_done;
        int          hold_bad;
        int          done_cnt;
        logic [27:0] hex_at_done;

        vecs[0]  = '{14'h1A3F,  1'b0, {S1, SA, S3, SF}, 1'b0, 1};
        vecs[1]  = '{14'd9999,  1'b1, {S9, S9, S9, S9}, 1'b0, 15};
        vecs[2]  = '{14'd12345, 1'b1, DASHES,           1'b1, 15};
        vecs[3]  = '{14'd7,     1'b1, {LZ, LZ, LZ, S7}, 1'b0, 15};
        vecs[4]  = '{14'h0000,  1'b0, {LZ, LZ, LZ, S0}, 1'b0, 1};
        vecs[5]  = '{14'h0B2C,  1'b0, {LZ, SB, S2, SC}, 1'b0, 1};
        vecs[6]  = '{14'h3FFF,  1'b0, {S3, SF, SF, SF}, 1'b0, 1};
        vecs[7]  = '{14'd10000, 1'b1, DASHES,           1'b1, 15};
        vecs[8]  = '{14'd1234,  1'b1, {S1, S2, S3, S4}, 1'b0, 15};
        vecs[9]  = '{14'd0,     1'b1, {LZ, LZ, LZ, S0}, 1'b0, 15};
        vecs[10] = '{14'd16383, 1'b1, DASHES,           1'b1, 15};
        vecs[11] = '{14'd42,    1'b1, {LZ, LZ, S4, S2}, 1'b0, 15};
        vecs[12] = '{14'd5678,  1'b1, {S5, S6, S7, S8}, 1'b0, 15};
        vecs[13] = '{14'h0800,  1'b0, {LZ, S8, S0, S0}, 1'b0, 1};

        resetn = 1'b0; value = '0; load = 1'b0; mode = 1'b0;
        repeat (3) @(negedge clock);
        check("reset_hex", 32'(hex), 32'(BLANK));
        check("reset_busy", 32'(busy), 0);
        check("reset_done", 32'(done), 0);
        check("reset_ovf", 32'(overflow), 0);
        resetn = 1'b1;

        // Table-driven vectors.
        for (int i = 0; i < 14; i++) begin
            run_load(vecs[i].value, vecs[i].mode, busy_n, got_done, hold_bad);
            check($sformatf("v%0d_done", i), 32'(got_done), 1);
            check($sformatf("v%0d_busy_cycles", i), 32'(busy_n), 32'(vecs[i].busy_n));
            check($sformatf("v%0d_hold", i), 32'(hold_bad), 0);
            check($sformatf("v%0d_hex", i), 32'(hex), 32'(vecs[i].hex));
            check($sformatf("v%0d_ovf", i), 32'(overflow), 32'(vecs[i].ovf));
            check($sformatf("v%0d_busy_at_done", i), 32'(busy), 0);
            @(negedge clock);
            check($sformatf("v%0d_done_single", i), 32'(done), 0);
            check($sformatf("v%0d_hex_kept", i), 32'(hex), 32'(vecs[i].hex));
        end

        // Load while busy is ignored: 100 decimal, then 55 (hex) at CONVERT cycle 5.
        @(negedge clock);
        value = 14'd100; mode = 1'b1; load = 1'b1;
        @(negedge clock);
        load = 1'b0;
        repeat (4) @(negedge clock);
        value = 14'd55; mode = 1'b0; load = 1'b1;
        @(negedge clock);
        load = 1'b0;
        done_cnt = 0; hex_at_done = '0;
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                done_cnt++;
                hex_at_done = hex;
            end
            @(negedge clock);
        end
        check("busyload_done_count", 32'(done_cnt), 1);
        check("busyload_hex", 32'(hex_at_done), 32'({LZ, S1, S0, S0}));
        check("busyload_ovf", 32'(overflow), 0);
        check("busyload_idle", 32'(busy), 0);

        // Load held across the update edge is ignored; load during the done cycle is taken.
        @(negedge clock);
        value = 14'h0012; mode = 1'b0; load = 1'b1;
        @(negedge clock);
        check("b2b_busy_first", 32'(busy), 1);
        @(negedge clock);
        check("b2b_done_first", 32'(done), 1);
        check("b2b_busy_after_update", 32'(busy), 0);
        check("b2b_hex_first", 32'(hex), 32'({LZ, LZ, S1, S2}));
        value = 14'h0345;
        @(negedge clock);
        load = 1'b0;
        check("b2b_busy_second", 32'(busy), 1);
        check("b2b_done_low", 32'(done), 0);
        @(negedge clock);
        check("b2b_done_second", 32'(done), 1);
        check("b2b_hex_second", 32'(hex), 32'({LZ, S3, S4, S5}));

        // Reset mid-conversion: first show an overflow so the reset has something to clear.
        run_load(14'd12345, 1'b1, busy_n, got_done, hold_bad);
        check("rst_pre_ovf", 32'(overflow), 1);
        @(negedge clock);
        value = 14'd1234; mode = 1'b1; load = 1'b1;
        @(negedge clock);
        load = 1'b0;
        repeat (7) @(negedge clock);
        resetn = 1'b0;
        #1;
        check("rst_hex", 32'(hex), 32'(BLANK));
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_ovf", 32'(overflow), 0);
        @(negedge clock);
        resetn = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            if (done) done_cnt++;
            @(negedge clock);
        end
        check("rst_no_done", 32'(done_cnt), 0);
        check("rst_hex_still_blank", 32'(hex), 32'(BLANK));
        run_load(14'd42, 1'b1, busy_n, got_done, hold_bad);
        check("rst_reload_done", 32'(got_done), 1);
        check("rst_reload_busy_cycles", 32'(busy_n), 15);
        check("rst_reload_hex", 32'(hex), 32'({LZ, LZ, S4, S2}));
        check("rst_reload_ovf", 32'(overflow), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
